uart_cmd_ctrl: RTL and testbench
================================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter BYTE_CYCLES, default 8680, input_clk cycles between consecutive trans_en pulses (one 10-bit UART frame).
REQ-002 Parameter ADDR_W, default 12, sample-memory address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000, max idle cycles between command and argument bytes.
REQ-004 Parameter DEV_ID, default 8'hA5, identity byte returned by ID command.
REQ-005 input_clk  in  1  sole clock, all logic on rising edge.
REQ-006 reset  in  1  one clock; reset is asynchronous and active-low (reset=0 resets).
REQ-007 data_received  in  8  byte from UART receiver, valid when data_rdy=1.
REQ-008 data_rdy  in  1  one-cycle pulse per received byte.
REQ-009 trans_en  out  1  one-cycle pulse launching one transmitted byte.
REQ-010 data_out  out  8  byte to transmit; registered, stable from trans_en until next trans_en.
REQ-011 rd_addr  out  ADDR_W  sample-memory read address, registered.
REQ-012 rd_data  in  8  sample-memory data, valid exactly one cycle after rd_addr changes.
REQ-013 arm  out  1  one-cycle pulse arming capture.
REQ-014 clear  out  1  one-cycle pulse clearing capture.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 cmd_err  out  1  one-cycle pulse on unknown opcode or argument timeout.

Function
REQ-017 Opcodes: 0x01 ARM, 0x02 CLEAR, 0x03 READ (two argument bytes, length hi then lo), 0x04 ID; all others unknown.
REQ-018 FSM states IDLE, ARG_HI, ARG_LO, RD_REQ, RD_WAIT, SEND, GAP, CKSUM; state encoding in package.
REQ-019 IDLE + data_rdy with ARM/CLEAR: arm/clear pulse on next cycle, remain IDLE, nothing transmitted.
REQ-020 IDLE + data_rdy with ID: trans_en with data_out=DEV_ID on next cycle, then GAP.
REQ-021 IDLE + data_rdy with unknown opcode: cmd_err and trans_en with data_out=0xEE on next cycle, then GAP.
REQ-022 READ: IDLE->ARG_HI->ARG_LO on successive data_rdy; length = {hi,lo}, 16-bit unsigned.
REQ-023 In ARG_HI/ARG_LO, TIMEOUT_CYCLES cycles without data_rdy -> cmd_err pulse, return IDLE, no transmission.
REQ-024 Length nonzero: rd_addr=0 one cycle after lo byte, first trans_en exactly 3 cycles after lo-byte data_rdy, data_out=rd_data.
REQ-025 Byte k (0-based) read from rd_addr = k mod 2^ADDR_W; wrap-around without error.
REQ-026 Consecutive trans_en pulses separated by exactly BYTE_CYCLES cycles; GAP counter counts BYTE_CYCLES-1 down to 0.
REQ-027 Length zero: no data bytes; return IDLE (or CKSUM per REQ-033).
REQ-028 After last byte's GAP expires, return IDLE; busy falls same cycle.
REQ-029 data_rdy in RD_REQ, RD_WAIT, SEND, GAP, CKSUM ignored (byte dropped, no state change).
REQ-030 Outputs arm, clear, trans_en, cmd_err never asserted together.

Reset
REQ-031 reset=0 asynchronously forces IDLE; trans_en, arm, clear, cmd_err, busy=0; data_out=0x00; rd_addr=0; counters=0.
REQ-032 Reset mid-READ aborts stream immediately; no further trans_en after release until a new command.

Configuration
REQ-033 Macro UART_CMD_CHECKSUM_EN defined: after READ stream (including length zero), CKSUM sends one extra byte = XOR of all data bytes sent (0x00 for length zero), one GAP after last data byte; undefined: no CKSUM state logic, stream ends after last data byte.

Structure
REQ-034 Package uart_cmd_pkg holds opcode constants, 0xEE error byte, FSM state enum.
REQ-035 Sub-module uart_cmd_gap_timer: loadable down-counter shared for GAP pacing and argument timeout.

Verification
REQ-036 Send 0x04 -> one trans_en, data_out=0xA5, busy high BYTE_CYCLES cycles.
REQ-037 Send 0x03,0x00,0x03; memory {0x11,0x22,0x33} -> trans_en 3 cycles after last byte, bytes 0x11,0x22,0x33 spaced BYTE_CYCLES; with UART_CMD_CHECKSUM_EN extra byte 0x00.
REQ-038 Send 0x7F -> cmd_err pulse, data_out=0xEE transmitted, return IDLE.
REQ-039 Send 0x03,0x00 then silence TIMEOUT_CYCLES -> cmd_err pulse, no trans_en, IDLE.
REQ-040 ADDR_W=2, READ length 6 -> rd_addr sequence 0,1,2,3,0,1.
REQ-041 Reset=0 during second byte of READ length 4 -> outputs zero immediately, no trans_en afterwards; bytes arriving mid-stream (e.g. 0x01) produce no arm.

Source files
------------

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller.
// Holds the opcode values, the byte returned for an unknown opcode, and the
// controller state encoding. Imported by the controller top.
package uart_cmd_pkg;

   localparam logic [7:0] OP_ARM   = 8'h01;
   localparam logic [7:0] OP_CLEAR = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_ID    = 8'h04;

   localparam logic [7:0] ERR_BYTE = 8'hEE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARG_HI,
      ST_ARG_LO,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_SEND,
      ST_GAP,
      ST_CKSUM
   } state_t;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bus between the UART command controller and its surroundings.
// slave  : controller side (receives UART bytes and memory data, drives
//          transmit, memory address and capture control).
// master : environment side (UART receiver/transmitter, sample memory).
// Signals: data_received/data_rdy (rx byte), trans_en/data_out (tx byte),
//          rd_addr/rd_data (sample memory), arm/clear (capture control),
//          busy, cmd_err (status).
interface uart_cmd_ctrl_if #(
   parameter int ADDR_W = 12
);
   logic [7:0]        data_received;
   logic              data_rdy;
   logic              trans_en;
   logic [7:0]        data_out;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data;
   logic              arm;
   logic              clear;
   logic              busy;
   logic              cmd_err;

   modport slave (
      input  data_received, data_rdy, rd_data,
      output trans_en, data_out, rd_addr, arm, clear, busy, cmd_err
   );

   modport master (
      output data_received, data_rdy, rd_data,
      input  trans_en, data_out, rd_addr, arm, clear, busy, cmd_err
   );
endinterface

// File: rtl/uart_cmd_ctrl_gap_timer.sv
// Loadable down-counter shared between transmit pacing and the argument
// timeout. Loads on i_load, otherwise counts down and holds at zero.
// Ports: i_clk, i_rst_n (async active-low), i_load, i_load_val,
//        o_zero (terminal count; suppressed while a load is pending so a
//        stale zero from the previous use is never seen).
module uart_cmd_gap_timer #(
   parameter int W = 20
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);
   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_count <= '0;
      else if (i_load)
         r_count <= i_load_val;
      else if (r_count != '0)
         r_count <= r_count - W'(1);
   end

   assign o_zero = (r_count == '0) && !i_load;
endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller.
// Decodes single-byte commands from a UART receiver: ARM/CLEAR pulse the
// capture controls, ID returns DEV_ID, READ takes a 16-bit length and
// streams that many sample-memory bytes, one per BYTE_CYCLES.
// Ports: input_clk, reset (async active-low), bus (uart_cmd_ctrl_if.slave).
// Build option: UART_CMD_CHECKSUM_EN appends an XOR checksum byte to every
// READ stream, including zero-length ones.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for an opcode
// ST_ARG_HI  | READ: waiting for length high byte (timeout armed)
// ST_ARG_LO  | READ: waiting for length low byte (timeout armed)
// ST_RD_REQ  | first sample address presented
// ST_RD_WAIT | first sample data returning, launched at end of cycle
// ST_SEND    | data byte launched this cycle, step to next address
// ST_GAP     | pacing until the next byte slot (or end of response)
// ST_CKSUM   | checksum byte launched, pacing until done
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int         BYTE_CYCLES    = 8680,
   parameter int         ADDR_W         = 12,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0] DEV_ID         = 8'hA5
) (
   input logic            input_clk,
   input logic            reset,
   uart_cmd_ctrl_if.slave bus
);
   localparam int TMR_MAX = (BYTE_CYCLES > TIMEOUT_CYCLES) ? BYTE_CYCLES : TIMEOUT_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   // The load pulse is registered, so the counter starts one cycle after the
   // decision; presetting two short lands terminal count on the last cycle
   // of the window.
   localparam logic [TMR_W-1:0] GAP_PRESET = TMR_W'(BYTE_CYCLES - 2);
   localparam logic [TMR_W-1:0] TO_PRESET  = TMR_W'(TIMEOUT_CYCLES - 2);

   state_t            r_state;
   logic              r_busy, r_trans_en, r_arm, r_clear, r_cmd_err;
   logic [7:0]        r_data_out, r_len_hi;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [15:0]       r_remain;
   logic              r_stream, r_err_pend;
   logic              r_tmr_load;
   logic [TMR_W-1:0]  r_tmr_val;
   logic              w_tmr_zero;
`ifdef UART_CMD_CHECKSUM_EN
   logic [7:0]        r_xor;
`endif

   uart_cmd_gap_timer #(.W(TMR_W)) u_timer (
      .i_clk      (input_clk),
      .i_rst_n    (reset),
      .i_load     (r_tmr_load),
      .i_load_val (r_tmr_val),
      .o_zero     (w_tmr_zero)
   );

   always_ff @(posedge input_clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_trans_en <= 1'b0;
         r_arm      <= 1'b0;
         r_clear    <= 1'b0;
         r_cmd_err  <= 1'b0;
         r_data_out <= 8'h00;
         r_len_hi   <= 8'h00;
         r_rd_addr  <= '0;
         r_remain   <= 16'd0;
         r_stream   <= 1'b0;
         r_err_pend <= 1'b0;
         r_tmr_load <= 1'b0;
         r_tmr_val  <= '0;
`ifdef UART_CMD_CHECKSUM_EN
         r_xor      <= 8'h00;
`endif
      end else begin
         r_trans_en <= 1'b0;
         r_arm      <= 1'b0;
         r_clear    <= 1'b0;
         r_cmd_err  <= 1'b0;
         r_tmr_load <= 1'b0;
         case (r_state)
            ST_IDLE: if (bus.data_rdy) begin
               case (bus.data_received)
                  OP_ARM:   r_arm   <= 1'b1;
                  OP_CLEAR: r_clear <= 1'b1;
                  OP_READ: begin
                     r_state    <= ST_ARG_HI;
                     r_busy     <= 1'b1;
                     r_tmr_load <= 1'b1;
                     r_tmr_val  <= TO_PRESET;
                  end
                  OP_ID: begin
                     r_trans_en <= 1'b1;
                     r_data_out <= DEV_ID;
                     r_stream   <= 1'b0;
                     r_state    <= ST_GAP;
                     r_busy     <= 1'b1;
                     r_tmr_load <= 1'b1;
                     r_tmr_val  <= GAP_PRESET;
                  end
                  default: begin
                     // error byte goes out first; cmd_err follows one cycle
                     // later so the two pulses never overlap
                     r_trans_en <= 1'b1;
                     r_data_out <= ERR_BYTE;
                     r_err_pend <= 1'b1;
                     r_stream   <= 1'b0;
                     r_state    <= ST_GAP;
                     r_busy     <= 1'b1;
                     r_tmr_load <= 1'b1;
                     r_tmr_val  <= GAP_PRESET;
                  end
               endcase
            end
            ST_ARG_HI: begin
               if (bus.data_rdy) begin
                  r_len_hi   <= bus.data_received;
                  r_state    <= ST_ARG_LO;
                  r_tmr_load <= 1'b1;
                  r_tmr_val  <= TO_PRESET;
               end else if (w_tmr_zero) begin
                  r_cmd_err <= 1'b1;
                  r_state   <= ST_IDLE;
                  r_busy    <= 1'b0;
               end
            end
            ST_ARG_LO: begin
               if (bus.data_rdy) begin
                  if ({r_len_hi, bus.data_received} != 16'd0) begin
                     r_remain  <= {r_len_hi, bus.data_received};
                     r_rd_addr <= '0;
                     r_stream  <= 1'b1;
                     r_state   <= ST_RD_REQ;
`ifdef UART_CMD_CHECKSUM_EN
                     r_xor     <= 8'h00;
                  end else begin
                     r_trans_en <= 1'b1;
                     r_data_out <= 8'h00;
                     r_state    <= ST_CKSUM;
                     r_tmr_load <= 1'b1;
                     r_tmr_val  <= GAP_PRESET;
                  end
`else
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
`endif
               end else if (w_tmr_zero) begin
                  r_cmd_err <= 1'b1;
                  r_state   <= ST_IDLE;
                  r_busy    <= 1'b0;
               end
            end
            ST_RD_REQ: r_state <= ST_RD_WAIT;
            ST_RD_WAIT: begin
               r_trans_en <= 1'b1;
               r_data_out <= bus.rd_data;
               r_remain   <= r_remain - 16'd1;
               r_state    <= ST_SEND;
               r_tmr_load <= 1'b1;
               r_tmr_val  <= GAP_PRESET;
`ifdef UART_CMD_CHECKSUM_EN
               r_xor      <= r_xor ^ bus.rd_data;
`endif
            end
            ST_SEND: begin
               // next sample settles long before the gap expires
               r_rd_addr <= r_rd_addr + ADDR_W'(1);
               r_state   <= ST_GAP;
            end
            ST_GAP: begin
               if (r_err_pend) begin
                  r_cmd_err  <= 1'b1;
                  r_err_pend <= 1'b0;
               end
               if (w_tmr_zero) begin
                  if (r_stream && (r_remain != 16'd0)) begin
                     r_trans_en <= 1'b1;
                     r_data_out <= bus.rd_data;
                     r_remain   <= r_remain - 16'd1;
                     r_state    <= ST_SEND;
                     r_tmr_load <= 1'b1;
                     r_tmr_val  <= GAP_PRESET;
`ifdef UART_CMD_CHECKSUM_EN
                     r_xor      <= r_xor ^ bus.rd_data;
                  end else if (r_stream) begin
                     r_trans_en <= 1'b1;
                     r_data_out <= r_xor;
                     r_state    <= ST_CKSUM;
                     r_tmr_load <= 1'b1;
                     r_tmr_val  <= GAP_PRESET;
`endif
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CKSUM: if (w_tmr_zero) begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
`endif
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.trans_en = r_trans_en;
   assign bus.data_out = r_data_out;
   assign bus.rd_addr  = r_rd_addr;
   assign bus.arm      = r_arm;
   assign bus.clear    = r_clear;
   assign bus.busy     = r_busy;
   assign bus.cmd_err  = r_cmd_err;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl. Stimulus tasks push the expected
// output events (kind, byte, address, absolute cycle) into a queue; a
// negedge monitor pops and compares whenever the DUT pulses an output.
module tb_uart_cmd_ctrl;
   localparam int         BC    = 20;
   localparam int         TO    = 50;
   localparam int         AW    = 2;
   localparam logic [7:0] DEVID = 8'hA5;

   localparam int K_TX  = 0;
   localparam int K_ARM = 1;
   localparam int K_CLR = 2;
   localparam int K_ERR = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         addr;
      int         cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   uart_cmd_ctrl_if #(.ADDR_W(AW)) bus ();

   uart_cmd_ctrl #(
      .BYTE_CYCLES    (BC),
      .ADDR_W         (AW),
      .TIMEOUT_CYCLES (TO),
      .DEV_ID         (DEVID)
   ) dut (
      .input_clk (clk),
      .reset     (rst_n),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [4];
   always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ev_t        exp_q[$];
   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] last_tx = 8'h00;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic push_ev(input int kind, input logic [7:0] data, input int addr, input int c);
      ev_t e;
      e.kind = kind; e.data = data; e.addr = addr; e.cyc = c;
      exp_q.push_back(e);
   endtask

   // monitor
   int  m_act;
   int  m_kind;
   ev_t m_e;
   always @(negedge clk) begin
      if (!rst_n) begin
         last_tx = 8'h00;
      end else begin
         m_act = int'(bus.trans_en) + int'(bus.arm) + int'(bus.clear) + int'(bus.cmd_err);
         if (m_act != 0) begin
            chk("pulse_exclusive", m_act, 1);
            m_kind = bus.trans_en ? K_TX : bus.arm ? K_ARM : bus.clear ? K_CLR : K_ERR;
            if (exp_q.size() == 0) begin
               chk("unexpected_event_kind", m_kind, -1);
            end else begin
               m_e = exp_q.pop_front();
               chk("ev_kind", m_kind, m_e.kind);
               chk("ev_cycle", cyc, m_e.cyc);
               if (m_kind == K_TX) begin
                  chk("tx_data", int'(bus.data_out), int'(m_e.data));
                  if (m_e.addr >= 0) chk("rd_addr", int'(bus.rd_addr), m_e.addr);
               end
            end
            if (bus.trans_en) last_tx = bus.data_out;
         end else begin
            chk("data_out_hold", int'(bus.data_out), int'(last_tx));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, output int n);
      @(posedge clk); #1;
      bus.data_received = b;
      bus.data_rdy      = 1'b1;
      n                 = cyc;
      @(posedge clk); #1;
      bus.data_rdy      = 1'b0;
      bus.data_received = 8'($urandom);
   endtask

   task automatic idle(input int k);
      repeat (k) begin @(posedge clk); #1; end
   endtask

   task automatic expect_idle(input int exp_cyc);
      int lim = 0;
      while (bus.busy && lim < 4000) begin @(posedge clk); #1; lim++; end
      chk("idle_cycle", bus.busy ? -1 : cyc, exp_cyc);
      @(negedge clk); #1;
      chk("events_drained", exp_q.size(), 0);
   endtask

   task automatic do_simple(input logic [7:0] op);
      int n;
      send_byte(op, n);
      case (op)
         8'h01: push_ev(K_ARM, 8'h00, -1, n + 1);
         8'h02: push_ev(K_CLR, 8'h00, -1, n + 1);
         8'h04: push_ev(K_TX, DEVID, -1, n + 1);
         default: begin
            push_ev(K_TX, 8'hEE, -1, n + 1);
            push_ev(K_ERR, 8'h00, -1, n + 2);
         end
      endcase
      chk("busy_after_op", int'(bus.busy), (op == 8'h01 || op == 8'h02) ? 0 : 1);
      expect_idle((op == 8'h01 || op == 8'h02) ? n + 1 : n + 1 + BC);
   endtask

   task automatic rand_mem();
      for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
   endtask

   // launch a READ; returns cycle of the low length byte and the expected
   // cycle at which busy drops
   task automatic start_read(input int len, output int n, output int idle_at);
      logic [7:0] x;
      int         m;
      send_byte(8'h03, m);
      idle($urandom_range(0, 3));
      send_byte(8'(len >> 8), m);
      idle($urandom_range(0, 3));
      send_byte(8'(len), n);
      x = 8'h00;
      for (int k = 0; k < len; k++) begin
         push_ev(K_TX, mem[k % 4], k % 4, n + 3 + k * BC);
         x = x ^ mem[k % 4];
      end
`ifdef UART_CMD_CHECKSUM_EN
      if (len == 0) begin
         push_ev(K_TX, 8'h00, -1, n + 1);
         idle_at = n + 1 + BC;
      end else begin
         push_ev(K_TX, x, -1, n + 3 + len * BC);
         idle_at = n + 3 + (len + 1) * BC;
      end
`else
      idle_at = (len == 0) ? n + 1 : n + 3 + len * BC;
`endif
   endtask

   task automatic do_read(input int len, input bit inject);
      int n, idle_at, m;
      start_read(len, n, idle_at);
      if (inject && len > 0) begin
         idle(2);
         send_byte(($urandom_range(0, 1) == 0) ? 8'h01 : 8'($urandom), m);
      end
      expect_idle(idle_at);
   endtask

   task automatic do_timeout(input bit after_hi);
      int n;
      send_byte(8'h03, n);
      if (after_hi) begin idle(1); send_byte(8'h00, n); end
      push_ev(K_ERR, 8'h00, -1, n + TO + 1);
      expect_idle(n + TO + 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, idle_at, r;
      logic [7:0] b;
      rst_n = 1'b0;
      bus.data_rdy = 1'b0;
      bus.data_received = 8'h00;
      rand_mem();
      #2;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_pulses", int'({bus.trans_en, bus.arm, bus.clear, bus.cmd_err}), 0);
      chk("rst_data_out", int'(bus.data_out), 0);
      chk("rst_rd_addr", int'(bus.rd_addr), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);

      do_simple(8'h04);
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
      do_read(3, 1'b0);
      do_simple(8'h7F);
      do_timeout(1'b1);
      do_timeout(1'b0);
      rand_mem();
      do_read(6, 1'b0);
      do_read(0, 1'b0);
      do_simple(8'h01);
      do_simple(8'h02);
      do_read(2, 1'b1);

      // reset in the middle of a length-4 stream
      rand_mem();
      start_read(4, n, idle_at);
      idle(BC + 4);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_pulses", int'({bus.trans_en, bus.arm, bus.clear, bus.cmd_err}), 0);
      chk("midrst_data_out", int'(bus.data_out), 0);
      chk("midrst_rd_addr", int'(bus.rd_addr), 0);
`ifdef UART_CMD_CHECKSUM_EN
      chk("midrst_bytes_sent", exp_q.size(), 3);
`else
      chk("midrst_bytes_sent", exp_q.size(), 2);
`endif
      exp_q.delete();
      idle(2);
      rst_n = 1'b1;
      idle(4 * BC);
      chk("midrst_busy_after", int'(bus.busy), 0);
      do_simple(8'h01);

      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(0, 5);
         case (r)
            0: do_simple(8'h01);
            1: do_simple(8'h02);
            2: do_simple(8'h04);
            3: begin
               b = 8'($urandom);
               if (b >= 8'h01 && b <= 8'h04) b = b | 8'h80;
               do_simple(b);
            end
            default: begin
               rand_mem();
               do_read($urandom_range(0, 5), 1'($urandom));
            end
         endcase
         idle($urandom_range(0, 4));
      end

      idle(5);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
